// File: rtl/memory_arbiter_if.sv
// -----------------------------------------------------------------------------
// memory_arbiter_if
//   Groups the dcache, icache and RAM handshake/bus signals of the memory
//   arbiter into one bundle.
//   slave  : the arbiter's view (receives cache requests and ram_ack/ramload,
//            drives the waits, loads and RAM strobes).
//   master : the environment's view (caches plus RAM model).
// Signals
//   dREN/dWEN/daddr/dstore  dcache request, address and write data
//   dwait/dload             dcache completion (active-low wait) and read data
//   iREN/iaddr              icache read request and address
//   iwait/iload             icache completion (active-low wait) and read data
//   ramREN/ramWEN           RAM read/write strobes
//   ramaddr/ramstore        RAM address and write data
//   ramload/ram_ack         RAM read data and access-complete flag
// -----------------------------------------------------------------------------
interface memory_arbiter_if;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dwait;
   logic [31:0] dload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic        ram_ack;

   modport slave (
      input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ram_ack,
      output dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ram_ack,
      input  dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//   Responder end of the cache-control protocol. Serialises dcache (read or
//   write) and icache (read) word requests onto a single-ported RAM. Each
//   access costs one IDLE arbitration cycle followed by a grant state that
//   lasts until the RAM acks (or the requester withdraws).
//   The dcache has priority, but after STARVE_LIMIT consecutive dcache grants
//   taken while the icache was waiting, the icache is forced in.
// Parameters
//   STARVE_LIMIT  consecutive dcache grants tolerated while iREN is pending
//   CNT_W         access counter width (only with ACCESS_COUNTER_EN)
// Ports
//   CLK           clock, all state on posedge
//   nRST          synchronous active-low reset
//   bus           memory_arbiter_if.slave (cache and RAM handshakes)
//   d_reads/d_writes/i_reads  completed-access counters (ACCESS_COUNTER_EN)
// Configuration macro
//   ACCESS_COUNTER_EN  when defined, adds the completed-access counters.
// -----------------------------------------------------------------------------
module memory_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
`ifdef ACCESS_COUNTER_EN
   ,
   parameter int unsigned CNT_W = 32
`endif
) (
   input  logic                  CLK,
   input  logic                  nRST,
   memory_arbiter_if.slave       bus
`ifdef ACCESS_COUNTER_EN
   ,
   output logic [CNT_W-1:0]      d_reads,
   output logic [CNT_W-1:0]      d_writes,
   output logic [CNT_W-1:0]      i_reads
`endif
);

   localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      D_GNT = 2'd1,
      I_GNT = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic                d_req_s;

   assign d_req_s = bus.dREN | bus.dWEN;

   // State and grant-streak registers
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q  <= IDLE;
         streak_q <= {STREAK_W{1'b0}};
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
      end
   end

   // Arbitration, grant outputs and completion handling
   always_comb begin
      state_d      = state_q;
      streak_d     = streak_q;
      bus.dwait    = 1'b1;
      bus.iwait    = 1'b1;
      bus.dload    = 32'h0000_0000;
      bus.iload    = 32'h0000_0000;
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = 32'h0000_0000;
      bus.ramstore = 32'h0000_0000;

      case (state_q)
         IDLE: begin
            if (d_req_s && bus.iREN && (streak_q == STREAK_MAX)) begin
               // icache has waited out STARVE_LIMIT dcache grants
               state_d  = I_GNT;
               streak_d = {STREAK_W{1'b0}};
            end else if (d_req_s) begin
               state_d = D_GNT;
               if (!bus.iREN) begin
                  streak_d = {STREAK_W{1'b0}};
               end else if (streak_q != STREAK_MAX) begin
                  streak_d = streak_q + STREAK_W'(1);
               end else begin
                  streak_d = streak_q;
               end
            end else if (bus.iREN) begin
               state_d  = I_GNT;
               streak_d = {STREAK_W{1'b0}};
            end else begin
               state_d  = IDLE;
               streak_d = {STREAK_W{1'b0}};
            end
         end

         D_GNT: begin
            if (!d_req_s) begin
               // Requester withdrew: strobes stay low, no completion
               state_d = IDLE;
            end else begin
               // Live dcache inputs are followed through the whole grant
               bus.ramaddr  = bus.daddr;
               bus.ramstore = bus.dstore;
               bus.ramWEN   = bus.dWEN;
               bus.ramREN   = bus.dREN & ~bus.dWEN;
               if (bus.ram_ack) begin
                  bus.dwait = 1'b0;
                  bus.dload = bus.ramload;
                  state_d   = IDLE;
               end else begin
                  state_d   = D_GNT;
               end
            end
         end

         I_GNT: begin
            if (!bus.iREN) begin
               state_d = IDLE;
            end else begin
               bus.ramaddr = bus.iaddr;
               bus.ramREN  = 1'b1;
               if (bus.ram_ack) begin
                  bus.iwait = 1'b0;
                  bus.iload = bus.ramload;
                  state_d   = IDLE;
               end else begin
                  state_d   = I_GNT;
               end
            end
         end

         default: begin
            state_d  = IDLE;
            streak_d = {STREAK_W{1'b0}};
         end
      endcase
   end

`ifdef ACCESS_COUNTER_EN
   logic [CNT_W-1:0] d_reads_q,  d_reads_d;
   logic [CNT_W-1:0] d_writes_q, d_writes_d;
   logic [CNT_W-1:0] i_reads_q,  i_reads_d;
   logic             d_done_s, i_done_s;

   // A completion is an ack while the granted requester is still asking
   assign d_done_s = (state_q == D_GNT) && d_req_s && bus.ram_ack;
   assign i_done_s = (state_q == I_GNT) && bus.iREN && bus.ram_ack;

   // Counter next-state; a dcache access with both lines set counts as a write
   always_comb begin
      d_reads_d  = d_reads_q;
      d_writes_d = d_writes_q;
      i_reads_d  = i_reads_q;
      if (d_done_s && bus.dWEN) begin
         d_writes_d = d_writes_q + CNT_W'(1);
      end else if (d_done_s) begin
         d_reads_d  = d_reads_q + CNT_W'(1);
      end else begin
         d_reads_d  = d_reads_q;
      end
      if (i_done_s) begin
         i_reads_d = i_reads_q + CNT_W'(1);
      end else begin
         i_reads_d = i_reads_q;
      end
   end

   // Access counter registers
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         d_reads_q  <= {CNT_W{1'b0}};
         d_writes_q <= {CNT_W{1'b0}};
         i_reads_q  <= {CNT_W{1'b0}};
      end else begin
         d_reads_q  <= d_reads_d;
         d_writes_q <= d_writes_d;
         i_reads_q  <= i_reads_d;
      end
   end

   assign d_reads  = d_reads_q;
   assign d_writes = d_writes_q;
   assign i_reads  = i_reads_q;
`endif

endmodule
